dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the far end of the EX/MEM pipeline register. It samples the MemRead/MemWrite strobes, ALU address and store data that EX/MEM presents, and services each access over a fixed multi-cycle latency. While an access is in flight it raises `stall_o` to freeze the front of the pipeline. It returns read data, plus an error flag, to the MEM/WB register.

## Interface
Parameters:
- `MEM_WORDS`, default 256: number of 32-bit words in the storage array.
- `LATENCY`, default 3: cycles from request presentation to response; legal range 1..15.

Ports:
- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `MemRead_i`  in  1: load request from EX/MEM.
- `MemWrite_i`  in  1: store request from EX/MEM.
- `addr_i`  in  32: byte address (EX/MEM ALU result).
- `data_i`  in  32: store data (EX/MEM forwarded rt value).
- `data_o`  out  32: load data to MEM/WB.
- `stall_o`  out  1: pipeline freeze request; combinational.
- `err_o`  out  1: access fault flag, valid in the DONE cycle.

## Operation
- Storage is `MEM_WORDS` x 32 bits, word-addressed by `addr_i[31:2]`.
  - The array is zero at time 0.
  - Reset does not alter array contents.
- Request: `req = MemRead_i | MemWrite_i`, evaluated only in IDLE.
- Fault conditions. A request faults if any of the following holds:
  - `addr_i[1:0] != 0`;
  - `addr_i[31:2] >= MEM_WORDS`;
  - `MemRead_i & MemWrite_i` both high.
- States:
  - IDLE.
    - If `req` is high: latch op, word index, `data_i` and the fault bit.
    - Load the counter with `LATENCY-1`.
    - Go to WAIT, or directly to DONE when `LATENCY==1`.
    - With no request, stay in IDLE.
  - WAIT.
    - Decrement the counter.
    - When the counter reaches 0, go to DONE on that edge.
    - The transition edge performs the array write if the op is a store and the request did not fault.
    - On the same edge, a non-faulting load registers `array[index]` into `data_o`; a faulting load registers 0.
  - DONE. Lasts one cycle, then unconditionally returns to IDLE.
    - Inputs are not sampled in DONE: EX/MEM still holds the same request this cycle, and it must not be re-accepted.
- `stall_o = (IDLE & req) | WAIT`. It is low in DONE, so the pipeline advances at the end of DONE.
- `err_o` is registered: high only in the DONE cycle of a faulting access, otherwise 0.
- `data_o` holds its value until the next load reaches DONE. Stores and faulting stores leave `data_o` unchanged.
- A faulting store never modifies the array.

## Timing
- Reset (`rst_i` high at an edge):
  - state goes to IDLE;
  - `data_o` = 0, `err_o` = 0;
  - counter = 0;
  - any in-flight access is aborted and its pending store is dropped.
- After reset, `stall_o` follows `req` combinationally in IDLE.
- Request presented in cycle 0:
  - `stall_o` is high in cycles 0..`LATENCY-1`;
  - DONE occurs in cycle `LATENCY`, with `stall_o` low, `data_o` and `err_o` valid.
- Back-to-back: the next request can be presented in cycle `LATENCY+1`. The sustained rate is one access per `LATENCY+1` cycles.
- Read-after-write to the same word: the later load returns the stored value. The store is committed at its DONE edge, before any subsequent load is accepted.
- Asserting `rst_i` in the same edge as the WAIT-to-DONE transition takes priority: no write, no `data_o` update.
- Inputs are ignored during WAIT and DONE. Changes to `addr_i` or `data_i` mid-access have no effect.

## Test plan
- Reset, then store.
  - Stimulus: hold `rst_i` for 2 cycles; present `MemWrite_i`=1, `addr_i`=0x10, `data_i`=0xDEADBEEF with `LATENCY`=3.
  - Response: `stall_o` high for cycles 0-2 and low at cycle 3; `err_o`=0; word 4 = 0xDEADBEEF.
- Read-after-write.
  - Stimulus: load `addr_i`=0x10 presented in cycle 4.
  - Response: `data_o`=0xDEADBEEF in cycle 7; `stall_o` low in cycle 7.
- Misaligned store.
  - Stimulus: store to 0x12 with `data_i`=0x1.
  - Response: `err_o`=1 in the DONE cycle only; words 4 and 5 unchanged; `data_o` unchanged.
- Out-of-range load.
  - Stimulus: load `addr_i`=0x400 (word 256, `MEM_WORDS`=256).
  - Response: `err_o`=1 and `data_o`=0 in DONE.
- Simultaneous strobes.
  - Stimulus: `MemRead_i`=`MemWrite_i`=1 at 0x20.
  - Response: fault, no array change, `err_o`=1 in DONE.
- Mid-operation reset, and `LATENCY`=1.
  - Stimulus: store 0x55 to 0x8, then assert `rst_i` in cycle 1 of the access.
  - Response: word 2 stays 0; `stall_o` low in the cycle after reset.
  - `LATENCY`=1 variant: a load has `stall_o` high for exactly 1 cycle, with data in the next cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Bus between the EX/MEM register and the data-memory responder.
// The master drives the request strobes, address and store data; the slave returns load data, stall and error.
interface dmem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        err_o;

    modport master (output MemRead_i, MemWrite_i, addr_i, data_i,
                    input  data_o, stall_o, err_o);
    modport slave  (input  MemRead_i, MemWrite_i, addr_i, data_i,
                    output data_o, stall_o, err_o);
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder on the EX/MEM side of MEM.
// It freezes the front of the pipeline while an access is in flight.
module dmem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int LATENCY   = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               flt_q, flt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    // Storage powers up cleared and is deliberately left out of reset.
    logic [31:0]        mem_q [MEM_WORDS] = '{default: '0};

    logic               req;
    logic               in_flt;
    logic [IDX_W-1:0]   in_idx;
    logic               stall;
    logic               commit;
    logic               c_wr, c_rd, c_flt;
    logic [IDX_W-1:0]   c_idx;
    logic [31:0]        c_wdata;
    logic               mem_we;

    assign req    = bus.MemRead_i | bus.MemWrite_i;
    assign in_flt = (bus.addr_i[1:0] != 2'b00)
                  | (bus.addr_i[31:2] >= 30'(MEM_WORDS))
                  | (bus.MemRead_i & bus.MemWrite_i);
    assign in_idx = bus.addr_i[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        flt_d   = flt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        commit  = 1'b0;
        c_wr    = wr_q;
        c_rd    = rd_q;
        c_flt   = flt_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    wr_d    = bus.MemWrite_i;
                    rd_d    = bus.MemRead_i & ~bus.MemWrite_i;
                    flt_d   = in_flt;
                    idx_d   = in_idx;
                    wdata_d = bus.data_i;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // Single-cycle access commits straight from the bus.
                        state_d = DONE;
                        commit  = 1'b1;
                        c_wr    = bus.MemWrite_i;
                        c_rd    = bus.MemRead_i & ~bus.MemWrite_i;
                        c_flt   = in_flt;
                        c_idx   = in_idx;
                        c_wdata = bus.data_i;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                // EX/MEM still shows this request; do not look at the bus.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            err_d = c_flt;
            if (c_rd) data_d = c_flt ? 32'h0 : mem_q[c_idx];
        end
    end

    assign mem_we = commit & c_wr & ~c_flt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            flt_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            flt_q   <= flt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Reset wins over a store committing on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) mem_q[c_idx] <= c_wdata;
    end

    assign bus.stall_o = stall;
    assign bus.data_o  = data_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder at LATENCY 3 and LATENCY 1.
// A word-array reference model supplies every expected load value and fault flag.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if b3();
    dmem_responder_if b1();

    dmem_responder #(.MEM_WORDS(256), .LATENCY(3)) u_l3 (.clk_i(clk), .rst_i(rst), .bus(b3));
    dmem_responder #(.MEM_WORDS(256), .LATENCY(1)) u_l1 (.clk_i(clk), .rst_i(rst), .bus(b1));

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl   [2][256];
    logic [31:0] dexp  [2];
    bit          dknown[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            b1.MemRead_i = rd; b1.MemWrite_i = wr; b1.addr_i = a; b1.data_i = d;
        end else begin
            b3.MemRead_i = rd; b3.MemWrite_i = wr; b3.addr_i = a; b3.data_i = d;
        end
    endtask

    function automatic logic get_stall(input bit s);
        return s ? b1.stall_o : b3.stall_o;
    endfunction
    function automatic logic get_err(input bit s);
        return s ? b1.err_o : b3.err_o;
    endfunction
    function automatic logic [31:0] get_data(input bit s);
        return s ? b1.data_o : b3.data_o;
    endfunction

    // Starts and ends at a cycle start (just after a rising edge).
    task automatic access(input bit s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, input string tag);
        int          lat;
        int unsigned w;
        bit          flt;
        lat = s ? 1 : 3;
        set_in(s, rd, wr, a, d);
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk($sformatf("%s_stall%0d", tag, c), 32'(get_stall(s)), 32'd1);
            @(posedge clk); #1;
            if (scramble) set_in(s, rd, wr, $urandom, $urandom);
        end
        w   = a >> 2;
        flt = (a[1:0] != 2'b00) || (w >= 256) || (rd && wr);
        if (wr && !rd && !flt) mdl[s][w] = d;
        if (rd && !wr) begin
            dexp[s]   = flt ? 32'h0 : mdl[s][w];
            dknown[s] = 1'b1;
        end
        if (rd && wr) dknown[s] = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_stall_done", tag), 32'(get_stall(s)), 32'd0);
        chk($sformatf("%s_err", tag), 32'(get_err(s)), 32'(flt));
        if (dknown[s]) chk($sformatf("%s_data", tag), get_data(s), dexp[s]);
        @(posedge clk); #1;
        set_in(s, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle_chk(input bit s, input string tag);
        @(negedge clk);
        chk($sformatf("%s_idle_stall", tag), 32'(get_stall(s)), 32'd0);
        chk($sformatf("%s_idle_err", tag), 32'(get_err(s)), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_access(input bit s, input int n);
        int          kind;
        logic        rd, wr;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        rd   = $urandom_range(0, 1);
        wr   = ~rd;
        case (kind)
            0:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            1:       a = 32'($urandom_range(256, 4095)) << 2;
            2:       begin a = 32'($urandom_range(0, 15)) << 2; rd = 1'b1; wr = 1'b1; end
            default: a = 32'($urandom_range(0, 15)) << 2;
        endcase
        access(s, rd, wr, a, $urandom, bit'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", s, n));
    endtask

    task automatic after_reset();
        dexp[0] = 32'h0; dexp[1] = 32'h0;
        dknown[0] = 1'b1; dknown[1] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mdl[0][i] = 32'h0; mdl[1][i] = 32'h0; end
        after_reset();
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_stall%0d", s), 32'(get_stall(bit'(s))), 32'd0);
            chk($sformatf("rst_err%0d", s), 32'(get_err(bit'(s))), 32'd0);
            chk($sformatf("rst_data%0d", s), get_data(bit'(s)), 32'h0);
        end
        @(posedge clk); #1;

        // Directed sequence at LATENCY 3.
        access(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, "st10");
        access(0, 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, "raw10");
        access(0, 1'b0, 1'b1, 32'h12,  32'h1,        1'b1, "mis12");
        idle_chk(0, "mis12");
        access(0, 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, "ld10");
        access(0, 1'b1, 1'b0, 32'h14,  32'h0,        1'b0, "ld14");
        access(0, 1'b1, 1'b0, 32'h400, 32'h0,        1'b0, "oor400");
        access(0, 1'b1, 1'b1, 32'h20,  32'h12345678, 1'b0, "dual20");
        access(0, 1'b1, 1'b0, 32'h20,  32'h0,        1'b0, "ld20");
        access(0, 1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b1, "st3fc");
        access(0, 1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, "ld3fc");

        // Reset one cycle into a store: the store is dropped.
        set_in(0, 1'b0, 1'b1, 32'h8, 32'h55);
        @(negedge clk);
        chk("mrst_stall0", 32'(get_stall(0)), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        after_reset();
        @(negedge clk);
        chk("mrst_stall", 32'(get_stall(0)), 32'd0);
        chk("mrst_err",   32'(get_err(0)),   32'd0);
        chk("mrst_data",  get_data(0),       32'h0);
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "ld8");

        // Reset on the WAIT-to-DONE edge: no write happens.
        set_in(0, 1'b0, 1'b1, 32'hC, 32'h77);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        after_reset();
        @(negedge clk);
        chk("erst_stall", 32'(get_stall(0)), 32'd0);
        chk("erst_err",   32'(get_err(0)),   32'd0);
        chk("erst_data",  get_data(0),       32'h0);
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, "ldC");

        for (int n = 0; n < 40; n++) rand_access(0, n);
        idle_chk(0, "rnd0_end");

        // LATENCY 1 instance.
        access(1, 1'b1, 1'b0, 32'h40, 32'h0,        1'b0, "l1_ld40a");
        access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, "l1_st40");
        access(1, 1'b1, 1'b0, 32'h40, 32'h0,        1'b0, "l1_ld40");
        access(1, 1'b1, 1'b0, 32'h41, 32'h0,        1'b0, "l1_mis41");
        access(1, 1'b1, 1'b0, 32'h400, 32'h0,       1'b0, "l1_oor");
        for (int n = 0; n < 30; n++) rand_access(1, n);
        idle_chk(1, "rnd1_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
